// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolution stage: condition codes and FSM
// state encoding.
package branch_pkg;

    localparam logic [3:0] COND_BEQ = 4'b0000;
    localparam logic [3:0] COND_BNE = 4'b0001;
    localparam logic [3:0] COND_BCS = 4'b0010;
    localparam logic [3:0] COND_BCC = 4'b0011;
    localparam logic [3:0] COND_BAL = 4'b1110;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TAKE  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational condition evaluator: decodes the branch function code and
// decides whether the branch is taken under the supplied carry/zero flags.
module branch_cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] i_funct,
    input  logic       i_c,
    input  logic       i_z,
    output logic       o_valid_code,
    output logic       o_taken,
    output logic       o_is_bal
);

    always_comb begin
        o_valid_code = 1'b1;
        o_taken      = 1'b0;
        o_is_bal     = 1'b0;
        case (i_funct)
            COND_BEQ: o_taken = i_z;
            COND_BNE: o_taken = ~i_z;
            COND_BCS: o_taken = i_c;
            COND_BCC: o_taken = ~i_c;
            COND_BAL: begin
                o_taken  = 1'b1;
                o_is_bal = 1'b1;
            end
            default:  o_valid_code = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Registered branch resolution: flag register with same-cycle forwarding,
// PC-relative target/link computation, take/flush sequencing and perf counters.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int PC_W         = 8,
    parameter int OFF_W        = 8,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flag_we,
    input  logic             alu_c,
    input  logic             alu_z,
    input  logic             br_valid,
    input  logic [3:0]       br_funct,
    input  logic [OFF_W-1:0] br_offset,
    input  logic [PC_W-1:0]  br_pc,
    output logic             br_ready,
    output logic             take_valid,
    output logic [PC_W-1:0]  take_target,
    output logic             link_we,
    output logic [PC_W-1:0]  link_data,
    output logic             flush,
    output logic             flag_c,
    output logic             flag_z,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] branch_cnt,
    output state_t           dbg_state
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    state_t            r_state;
    state_t            w_next_state;
    logic [FC_W-1:0]   r_flush_cnt;
    logic              r_flag_c;
    logic              r_flag_z;
    logic              r_is_bal;
    logic [PC_W-1:0]   r_target;
    logic [PC_W-1:0]   r_link;
    logic [CNT_W-1:0]  r_taken_cnt;
    logic [CNT_W-1:0]  r_branch_cnt;

    logic              w_eff_c;
    logic              w_eff_z;
    logic              w_valid_code;
    logic              w_taken;
    logic              w_is_bal;
    logic              w_accept;
    logic              w_take;
    logic [PC_W-1:0]   w_off_ext;
    logic [PC_W-1:0]   w_link;
    logic [PC_W-1:0]   w_target;

    // A flag write in the accept cycle is forwarded straight into the condition.
    assign w_eff_c = flag_we ? alu_c : r_flag_c;
    assign w_eff_z = flag_we ? alu_z : r_flag_z;

    branch_cond_eval u_cond (
        .i_funct      (br_funct),
        .i_c          (w_eff_c),
        .i_z          (w_eff_z),
        .o_valid_code (w_valid_code),
        .o_taken      (w_taken),
        .o_is_bal     (w_is_bal)
    );

    assign w_accept  = br_valid && br_ready && w_valid_code;
    assign w_take    = w_accept && w_taken;
    assign w_off_ext = PC_W'($signed(br_offset));
    assign w_link    = br_pc + PC_W'(1);
    assign w_target  = w_link + w_off_ext;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_take) w_next_state = ST_TAKE;
            ST_TAKE:  w_next_state = (FLUSH_CYCLES == 1) ? ST_IDLE : ST_FLUSH;
            ST_FLUSH: if (r_flush_cnt == FC_W'(1)) w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_TAKE)
                r_flush_cnt <= FC_W'(FLUSH_CYCLES - 1);
            else if (r_state == ST_FLUSH)
                r_flush_cnt <= r_flush_cnt - FC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flag_c <= 1'b0;
            r_flag_z <= 1'b0;
        end else if (flag_we) begin
            r_flag_c <= alu_c;
            r_flag_z <= alu_z;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target <= '0;
            r_link   <= '0;
            r_is_bal <= 1'b0;
        end else if (w_take) begin
            r_target <= w_target;
            r_link   <= w_link;
            r_is_bal <= w_is_bal;
        end
    end

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_branch_cnt <= '0;
            r_taken_cnt  <= '0;
        end else begin
            if (w_accept && (r_branch_cnt != '1))
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            if (w_take && (r_taken_cnt != '1))
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        end
    end

    assign br_ready    = (r_state == ST_IDLE);
    assign take_valid  = (r_state == ST_TAKE);
    assign link_we     = (r_state == ST_TAKE) && r_is_bal;
    assign flush       = (r_state == ST_TAKE) || (r_state == ST_FLUSH);
    assign take_target = r_target;
    assign link_data   = r_link;
    assign flag_c      = r_flag_c;
    assign flag_z      = r_flag_z;
    assign taken_cnt   = r_taken_cnt;
    assign branch_cnt  = r_branch_cnt;
    assign dbg_state   = r_state;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed + short random bench for branch_resolve_unit; a second instance with
// 2-bit counters shares the stimulus to exercise saturation.
module tb_branch_resolve_unit;
    import branch_pkg::*;

    localparam int PC_W = 8;
    localparam int OFF_W = 8;
    localparam int FC = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             flag_we = 1'b0;
    logic             alu_c = 1'b0;
    logic             alu_z = 1'b0;
    logic             br_valid = 1'b0;
    logic [3:0]       br_funct = 4'd0;
    logic [OFF_W-1:0] br_offset = '0;
    logic [PC_W-1:0]  br_pc = '0;

    logic             br_ready, take_valid, link_we, flush, flag_c, flag_z;
    logic [PC_W-1:0]  take_target, link_data;
    logic [15:0]      taken_cnt, branch_cnt;
    state_t           dbg_state;

    logic             d2_br_ready, d2_take_valid, d2_link_we, d2_flush, d2_flag_c, d2_flag_z;
    logic [PC_W-1:0]  d2_take_target, d2_link_data;
    logic [1:0]       d2_taken_cnt, d2_branch_cnt;
    state_t           d2_dbg_state;

    branch_resolve_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_c(alu_c), .alu_z(alu_z),
        .br_valid(br_valid), .br_funct(br_funct), .br_offset(br_offset), .br_pc(br_pc),
        .br_ready(br_ready), .take_valid(take_valid), .take_target(take_target),
        .link_we(link_we), .link_data(link_data), .flush(flush),
        .flag_c(flag_c), .flag_z(flag_z), .taken_cnt(taken_cnt), .branch_cnt(branch_cnt),
        .dbg_state(dbg_state)
    );

    branch_resolve_unit #(.PC_W(PC_W), .OFF_W(OFF_W), .FLUSH_CYCLES(FC), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flag_we(flag_we), .alu_c(alu_c), .alu_z(alu_z),
        .br_valid(br_valid), .br_funct(br_funct), .br_offset(br_offset), .br_pc(br_pc),
        .br_ready(d2_br_ready), .take_valid(d2_take_valid), .take_target(d2_take_target),
        .link_we(d2_link_we), .link_data(d2_link_data), .flush(d2_flush),
        .flag_c(d2_flag_c), .flag_z(d2_flag_z), .taken_cnt(d2_taken_cnt),
        .branch_cnt(d2_branch_cnt), .dbg_state(d2_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    // scoreboard: {is_bal, link, target}
    logic [2*PC_W:0] exp_q[$];
    int total = 0;
    int bad = 0;

    // reference state
    logic m_c = 1'b0;
    logic m_z = 1'b0;
    int   m_busy = 0;
    int   m_bcnt = 0;
    int   m_tcnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // One clock: model the edge from the currently driven inputs, then check.
    task automatic tick();
        logic ec, ez, valid, tk, bal, pend;
        logic [PC_W-1:0] lk, tg, off;
        logic [2*PC_W:0] e;
        ec = flag_we ? alu_c : m_c;
        ez = flag_we ? alu_z : m_z;
        valid = 1'b1; tk = 1'b0; bal = 1'b0;
        case (br_funct)
            4'b0000: tk = ez;
            4'b0001: tk = !ez;
            4'b0010: tk = ec;
            4'b0011: tk = !ec;
            4'b1110: begin tk = 1'b1; bal = 1'b1; end
            default: valid = 1'b0;
        endcase
        pend = 1'b0;
        if (br_valid && (m_busy == 0) && valid) begin
            m_bcnt++;
            if (tk) begin
                m_tcnt++;
                pend = 1'b1;
                off = br_offset;
                lk = br_pc + 8'd1;
                tg = lk + off;
                exp_q.push_back({bal, lk, tg});
            end
        end
        @(posedge clk);
        if (flag_we) begin m_c = alu_c; m_z = alu_z; end
        if (pend) m_busy = FC;
        else if (m_busy > 0) m_busy--;
        #1;
        chk("br_ready", 32'(br_ready), 32'(m_busy == 0));
        chk("flush", 32'(flush), 32'(m_busy > 0));
        chk("take_valid", 32'(take_valid), 32'(pend));
        if (take_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_take", 32'(take_valid), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("take_target", 32'(take_target), 32'(e[PC_W-1:0]));
                chk("link_we", 32'(link_we), 32'(e[2*PC_W]));
                if (e[2*PC_W]) chk("link_data", 32'(link_data), 32'(e[2*PC_W-1:PC_W]));
            end
        end else begin
            chk("link_we_idle", 32'(link_we), 32'd0);
        end
        chk("flag_c", 32'(flag_c), 32'(m_c));
        chk("flag_z", 32'(flag_z), 32'(m_z));
        chk("branch_cnt", 32'(branch_cnt), 32'(m_bcnt));
        chk("taken_cnt", 32'(taken_cnt), 32'(m_tcnt));
        chk("sat_branch_cnt", 32'(d2_branch_cnt), 32'(sat3(m_bcnt)));
        chk("sat_taken_cnt", 32'(d2_taken_cnt), 32'(sat3(m_tcnt)));
    endtask

    // driver tasks
    task automatic drive_flags(input logic c, input logic z);
        flag_we = 1'b1; alu_c = c; alu_z = z;
        tick();
        flag_we = 1'b0;
    endtask

    task automatic drive_branch(input logic [3:0] f, input logic [7:0] pc, input logic [7:0] off,
                                input logic fwe, input logic c, input logic z);
        br_valid = 1'b1; br_funct = f; br_pc = pc; br_offset = off;
        flag_we = fwe; alu_c = c; alu_z = z;
        tick();
        br_valid = 1'b0; flag_we = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    logic [3:0] codes [7];

    initial begin
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b1110, 4'b0101, 4'b1001};

        // reset values
        repeat (2) @(posedge clk);
        #2;
        chk("rst_br_ready", 32'(br_ready), 32'd1);
        chk("rst_take_valid", 32'(take_valid), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_link_we", 32'(link_we), 32'd0);
        chk("rst_take_target", 32'(take_target), 32'd0);
        chk("rst_link_data", 32'(link_data), 32'd0);
        chk("rst_flags", 32'({flag_c, flag_z}), 32'd0);
        chk("rst_counts", 32'({taken_cnt, branch_cnt}), 32'd0);
        rst_n = 1'b1;
        idle(1);

        // BEQ taken after z=1
        drive_flags(1'b0, 1'b1);
        drive_branch(4'b0000, 8'h10, 8'h05, 1'b0, 1'b0, 1'b0);
        idle(3);

        // BNE not taken then BCC taken back to back
        drive_branch(4'b0001, 8'h20, 8'h03, 1'b0, 1'b0, 1'b0);
        drive_branch(4'b0011, 8'h21, 8'h10, 1'b0, 1'b0, 1'b0);
        idle(3);

        // forwarded carry into BCS, wrap-around target
        drive_branch(4'b0010, 8'h00, 8'hFE, 1'b1, 1'b1, 1'b0);
        idle(3);

        // BAL with link wrap; br_valid held during TAKE/FLUSH is ignored
        drive_branch(4'b1110, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
        drive_branch(4'b0000, 8'h40, 8'h02, 1'b0, 1'b0, 1'b0);
        drive_branch(4'b1110, 8'h41, 8'h02, 1'b0, 1'b0, 1'b0);
        idle(1);

        // illegal code
        drive_branch(4'b0101, 8'h50, 8'h02, 1'b0, 1'b0, 1'b0);
        idle(2);

        // reset while in FLUSH
        drive_branch(4'b1110, 8'h60, 8'h04, 1'b0, 1'b0, 1'b0);
        tick();
        chk("pre_rst_state", 32'(dbg_state), 32'(ST_FLUSH));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_flush", 32'(flush), 32'd0);
        chk("arst_br_ready", 32'(br_ready), 32'd1);
        chk("arst_take_valid", 32'(take_valid), 32'd0);
        chk("arst_branch_cnt", 32'(branch_cnt), 32'd0);
        chk("arst_taken_cnt", 32'(taken_cnt), 32'd0);
        m_c = 1'b0; m_z = 1'b0; m_busy = 0; m_bcnt = 0; m_tcnt = 0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // five taken branches: 2-bit counters saturate at 3
        for (int i = 0; i < 5; i++) begin
            drive_branch(4'b1110, 8'(8'h70 + i), 8'(i), 1'b0, 1'b0, 1'b0);
            idle(2);
        end
        chk("sat_final_branch", 32'(d2_branch_cnt), 32'd3);
        chk("sat_final_taken", 32'(d2_taken_cnt), 32'd3);

        // random mix
        for (int i = 0; i < 40; i++) begin
            drive_branch(codes[$urandom_range(0, 6)], 8'($urandom_range(0, 255)),
                         8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(4);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
